instr_fetch_unit: RTL and testbench

- Consumer side of the program-counter interface: takes the current PC, fetches the instruction word from instruction memory over a req/gnt/rvalid bus, and holds it for decode until accepted.
- Sits between the program counter, the instruction memory port and the decode/control stage.
- Reports alignment and timeout faults to control.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Consumer side of the program-counter interface. It takes pc_current and
//   fetches one instruction word over a req/gnt/rvalid memory port. The word
//   is held for decode until instr_ready. Misalignment and timeout faults are
//   reported to control.
//
// Parameters
//   DATA_WIDTH      address / instruction width (default 32)
//   TIMEOUT_CYCLES  WAIT cycles without rvalid before a timeout fault (default 255)
//
// Optional feature (compile-time macro)
//   FETCH_MISALIGN_TRAP_EN
//     When defined, fetch_start with pc_addr_ok=0 issues no request.
//     Instead it raises fetch_fault with fault_cause=01.
//     When undefined, pc_addr_ok is ignored and the address is word-aligned.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   fetch_start           request a fetch of pc_current (sampled only when idle)
//   pc_current            address to fetch
//   pc_addr_ok            1 = pc_current is aligned
//   flush                 abort the current fetch; any pending response is discarded
//   mem_req/mem_addr      memory request, held until mem_gnt; addr[1:0] always 0
//   mem_gnt               memory accepted the request
//   mem_rvalid/mem_rdata  read response (one per grant)
//   instr_valid/instr/instr_pc  fetched word for decode, held until instr_ready
//   instr_ready           decode accepts the word
//   busy                  fetch unit is not idle
//   fetch_fault           one-cycle fault pulse
//   fault_cause           01 misaligned, 10 timeout; sticky until the next fault
module instr_fetch_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_start,
    input  logic [DATA_WIDTH-1:0] pc_current,
    input  logic                  pc_addr_ok,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  busy,
    output logic                  fetch_fault,
    output logic [1:0]            fault_cause
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         wait_cnt;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0] addr_q;
    logic                  trap_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_misalign = ~pc_addr_ok;
`else
    logic unused_addr_ok;
    assign unused_addr_ok = pc_addr_ok;
    assign trap_misalign  = 1'b0;
`endif

    assign cnt_inc = wait_cnt + 1'b1;

    // The handshake outputs are decoded straight from registered state.
    assign mem_req     = (state == S_REQ);
    assign instr_valid = (state == S_HOLD);
    assign busy        = (state != S_IDLE);
    assign mem_addr    = addr_q;
    assign instr_pc    = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            instr       <= '0;
            fetch_fault <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            fetch_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_start) begin
                        if (trap_misalign) begin
                            fetch_fault <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            addr_q <= pc_current & ~DATA_WIDTH'(3);
                            state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the flush cycle still owes us a response, so drain it.
                    if (mem_gnt) begin
                        wait_cnt <= '0;
                        state    <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (!flush) begin
                            instr <= mem_rdata;
                            state <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc == TO_LIMIT) begin
                            fetch_fault <= 1'b1;
                            fault_cause <= 2'b10;
                            state       <= S_DRAIN;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready || flush) state <= S_IDLE;
                end
                S_DRAIN: begin
                    // The response is still owed by memory; swallow it before going idle.
                    if (mem_rvalid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_start, pc_addr_ok, flush, mem_gnt, mem_rvalid, instr_ready;
    logic [DW-1:0] pc_current, mem_rdata;
    logic          mem_req, instr_valid, busy, fetch_fault;
    logic [DW-1:0] mem_addr, instr, instr_pc;
    logic [1:0]    fault_cause;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_current(pc_current),
        .pc_addr_ok(pc_addr_ok), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .busy(busy), .fetch_fault(fetch_fault),
        .fault_cause(fault_cause)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model.
    // The state of a fetch is tracked as separate facts:
    //   a request is being presented,
    //   a response is owed (and whether it is wanted),
    //   a word is held for decode.
    bit          m_req, m_owed, m_want, m_have, m_fault;
    int          m_waitc;
    logic [31:0] m_addr, m_instr;
    logic [1:0]  m_cause;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_owed = 0; m_want = 0; m_have = 0; m_fault = 0;
            m_waitc = 0; m_addr = '0; m_instr = '0; m_cause = 2'b00;
        end else begin
            bit f;
            bit idle;
            f    = 0;
            idle = !m_req && !m_owed && !m_have;
            if (idle) begin
                if (fetch_start) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (!pc_addr_ok) begin
                        f = 1;
                        m_cause = 2'b01;
                    end else begin
                        m_addr = pc_current & 32'hFFFF_FFFC;
                        m_req = 1;
                    end
`else
                    m_addr = pc_current & 32'hFFFF_FFFC;
                    m_req = 1;
`endif
                end
            end else if (m_req) begin
                if (mem_gnt) begin
                    m_req = 0; m_owed = 1; m_want = !flush; m_waitc = 0;
                end else if (flush) begin
                    m_req = 0;
                end
            end else if (m_owed && m_want) begin
                if (mem_rvalid) begin
                    m_owed = 0;
                    if (!flush) begin
                        m_have = 1;
                        m_instr = mem_rdata;
                    end
                end else if (flush) begin
                    m_want = 0;
                end else begin
                    m_waitc++;
                    if (m_waitc == TO) begin
                        m_want = 0; f = 1; m_cause = 2'b10;
                    end
                end
            end else if (m_owed) begin
                if (mem_rvalid) m_owed = 0;
            end else if (m_have) begin
                if (instr_ready || flush) m_have = 0;
            end
            m_fault = f;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_req", mem_req, m_req);
            chk("mem_addr", mem_addr, m_addr);
            chk("instr_pc", instr_pc, m_addr);
            chk("busy", busy, m_req | m_owed | m_have);
            chk("instr_valid", instr_valid, m_have);
            chk("instr", instr, m_instr);
            chk("fetch_fault", fetch_fault, m_fault);
            chk("fault_cause", fault_cause, m_cause);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_instr_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_instr_pc"}, instr_pc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fetch_fault"}, fetch_fault, 0);
        chk({tag, "_fault_cause"}, fault_cause, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1; fetch_start = 0; pc_current = '0; pc_addr_ok = 1; flush = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; instr_ready = 0;
        #2 rst_n = 0;
        #2 check_zero("reset");
        cyc(2);
        rst_n = 1;
        cyc(1);

        // Minimum-latency fetch: start@0, req/gnt@1, rvalid@2, instr_valid@3.
        pc_current = 32'h0000_0104; fetch_start = 1;
        cyc(1);
        fetch_start = 0;
        chk("basic_req", mem_req, 1);
        chk("basic_addr", mem_addr, 32'h104);
        mem_gnt = 1;
        cyc(1);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0051_0093;
        chk("basic_req_dropped", mem_req, 0);
        cyc(1);
        mem_rvalid = 0; mem_rdata = '0;
        chk("basic_valid", instr_valid, 1);
        chk("basic_instr", instr, 32'h0051_0093);
        chk("basic_pc", instr_pc, 32'h104);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
        chk("basic_idle", busy, 0);

        // Grant delayed by 3 cycles; decode stalls for 4 cycles.
        pc_current = 32'h0000_2008; fetch_start = 1;
        cyc(1);
        fetch_start = 0;
        cyc(3);
        chk("slow_req_held", mem_req, 1);
        chk("slow_addr", mem_addr, 32'h2008);
        mem_gnt = 1;
        cyc(1);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        cyc(1);
        mem_rvalid = 0;
        cyc(4);
        chk("slow_valid_held", instr_valid, 1);
        chk("slow_instr_held", instr, 32'h1234_5678);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
        chk("slow_idle", busy, 0);

        // Flush in WAIT, then the response arrives two cycles later and is dropped.
        pc_current = 32'h0000_0300; fetch_start = 1;
        cyc(1);
        fetch_start = 0; mem_gnt = 1;
        cyc(1);
        mem_gnt = 0; flush = 1;
        cyc(1);
        flush = 0;
        cyc(1);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        chk("flush_busy_drain", busy, 1);
        cyc(1);
        mem_rvalid = 0;
        chk("flush_busy_gone", busy, 0);
        chk("flush_no_valid", instr_valid, 0);
        chk("flush_instr_kept", instr, 32'h1234_5678);

        // Timeout: grant but no response for TO WAIT cycles.
        pc_current = 32'h0000_0400; fetch_start = 1;
        cyc(1);
        fetch_start = 0; mem_gnt = 1;
        cyc(1);
        mem_gnt = 0;
        cyc(3);
        chk("to_no_early_fault", fetch_fault, 0);
        cyc(1);
        chk("to_fault", fetch_fault, 1);
        chk("to_cause", fault_cause, 2'b10);
        cyc(1);
        chk("to_pulse_end", fetch_fault, 0);
        chk("to_draining", busy, 1);
        mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
        cyc(1);
        mem_rvalid = 0;
        chk("to_idle", busy, 0);
        chk("to_cause_sticky", fault_cause, 2'b10);

        // Misaligned PC.
        pc_current = 32'h0000_0102; pc_addr_ok = 0; fetch_start = 1;
        cyc(1);
        fetch_start = 0; pc_addr_ok = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_no_req", mem_req, 0);
        chk("mis_fault", fetch_fault, 1);
        chk("mis_cause", fault_cause, 2'b01);
        chk("mis_idle", busy, 0);
        cyc(1);
`else
        chk("mis_req", mem_req, 1);
        chk("mis_addr", mem_addr, 32'h100);
        mem_gnt = 1;
        cyc(1);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        cyc(1);
        mem_rvalid = 0;
        chk("mis_instr", instr, 32'h13);
        chk("mis_pc", instr_pc, 32'h100);
        chk("mis_cause_kept", fault_cause, 2'b10);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
`endif

        // Flush in REQ without and with a simultaneous grant.
        pc_current = 32'h0000_0500; fetch_start = 1;
        cyc(1);
        fetch_start = 0; flush = 1;
        cyc(1);
        flush = 0;
        chk("reqflush_idle", busy, 0);
        pc_current = 32'h0000_0600; fetch_start = 1;
        cyc(1);
        fetch_start = 0; flush = 1; mem_gnt = 1;
        cyc(1);
        flush = 0; mem_gnt = 0;
        chk("reqflush_gnt_drain", busy, 1);
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        cyc(1);
        mem_rvalid = 0;
        chk("reqflush_gnt_idle", busy, 0);
        chk("reqflush_no_valid", instr_valid, 0);

        // Reset in the middle of WAIT.
        pc_current = 32'h0000_0700; fetch_start = 1;
        cyc(1);
        fetch_start = 0; mem_gnt = 1;
        cyc(1);
        mem_gnt = 0;
        cyc(1);
        rst_n = 0;
        #1 check_zero("midreset");
        cyc(1);
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        cyc(1);
        mem_rvalid = 0;
        chk("midreset_rvalid_ignored", busy, 0);
        chk("midreset_no_valid", instr_valid, 0);
        chk("midreset_instr", instr, 0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
